control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named clk and clr.
REQ-002 clk  input  1  rising-edge clock shared with the datapath.
REQ-003 clr  input  1  asynchronous active-low reset.
REQ-004 IR  input  32  instruction register contents; opcode is IR[31:27].
REQ-005 CON  input  1  branch-condition flip-flop output from the datapath.
REQ-006 stop  input  1  level; halt after the current instruction completes.
REQ-007 PCout, PCin, IncPC, MARin  output  1 each  PC/MAR strobes.
REQ-008 MDRRead, MDRin, MDRout, IRin  output  1 each  memory-data strobes.
REQ-009 Gra, Grb, Grc, Rin_in, Rout_in, BAout  output  1 each  register select-logic strobes.
REQ-010 Yin, Zin, Zlowout, Cout  output  1 each  ALU operand and result strobes.
REQ-011 ALUControl  output  12  one-hot ALU operation; zero when idle.
REQ-012 CONin, brIn, con_FF_Reset  output  1 each  branch strobes.
REQ-013 run  output  1  high while sequencing; low in HALT.
REQ-014 state_dbg  output  5  current state encoding.

Function
REQ-015 The FSM SHALL be Moore: each state lasts exactly one clk cycle, and outputs decode from the state register and IR[31:27] only.
REQ-016 Fetch sequence SHALL be:
  T0: PCout, MARin, IncPC, Zin.
  T1: Zlowout, PCin, MDRRead, MDRin.
  T2: MDRout, IRin.
REQ-017 LDI (00001) SHALL run:
  T3: Grb, BAout, Yin.
  T4: Cout, ALUControl=12'h001, Zin.
  T5: Zlowout, Gra, Rin_in.
  Next state is T0.
REQ-018 ADD/SUB/AND/OR (00011/00100/00101/00110) SHALL run:
  T3: Grb, Rout_in, Yin.
  T4: Grc, Rout_in, Zin, ALUControl=12'h001/002/004/008 respectively.
  T5: Zlowout, Gra, Rin_in.
  Next state is T0.
REQ-019 BR (10010) SHALL run:
  T3: Gra, Rout_in, CONin.
  T4: PCout, Yin.
  T5: Cout, ALUControl=12'h001, Zin.
  T6: Zlowout, PCin, brIn.
  T7: con_FF_Reset only.
  Next state is T0.
REQ-020 NOP (11010) and every undefined opcode SHALL go T2 -> T0 with no further strobes.
REQ-021 HALT (11011) SHALL go T2 -> HALT; HALT holds with all strobes 0 and run=0 until clr.
REQ-022 stop sampled high on the final state of an instruction SHALL transition to HALT instead of T0; stop SHALL never truncate an instruction mid-sequence.
REQ-023 Every strobe not listed for a state SHALL be 0 in that state; ALUControl SHALL be nonzero only in T4/T5 as listed.
REQ-024 States SHALL be RST, T0–T7, HALT (plus WAIT per REQ-029); any illegal encoding SHALL go to RST.

Reset
REQ-025 clr low SHALL immediately force state RST, all outputs 0, run=0, state_dbg=RST code.
REQ-026 On the first clk edge after clr rises, the FSM SHALL go RST -> T0 with run=1.
REQ-027 clr asserted mid-instruction SHALL abort the instruction with no further strobes.

Configuration
REQ-028 Macro CONTROL_SEQUENCER_STEP_EN SHALL add input step (1 bit) and state WAIT.
REQ-029 With the macro defined, each instruction's final state SHALL go to WAIT (all strobes 0, run=1), and WAIT -> T0 on the cycle step is high.
REQ-030 Without the macro, there SHALL be no step port and no WAIT state, and the final state goes directly to T0.

Structure
REQ-031 A shared package SHALL hold the opcode constants, the ALUControl one-hot constants, and the state enumeration/encodings.
REQ-032 One sub-module, opcode_decoder (IR[31:27] -> instruction class and ALU op), is natural; the FSM stays in control_sequencer.

Verification
REQ-033 clr low then high, IR=0 -> RST, then T0 on the next edge with PCout=MARin=IncPC=Zin=1, run=1.
REQ-034 IR=LDI -> T3..T5 strobes exactly per REQ-017; ALUControl=12'h001 in T4; returns to T0 after 6 cycles.
REQ-035 IR=BR with CON=0 and again with CON=1 -> identical strobe sequence; con_FF_Reset high for exactly 1 cycle in T7; 8 cycles total.
REQ-036 IR=SUB with stop raised at T4 -> T5 completes, then HALT, run=0, all strobes 0.
REQ-037 clr pulsed low during BR T5 -> all outputs 0 within that cycle; RST -> T0 after release.
REQ-038 IR=5'b11111 -> T0, T1, T2, T0 with no T3 strobes; with CONTROL_SEQUENCER_STEP_EN defined, WAIT holds until step=1.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for control_sequencer: opcodes, ALU one-hot codes, states, strobe decode.
// Optional single-step support is enabled with CONTROL_SEQUENCER_STEP_EN (adds S_WAIT).
package control_sequencer_pkg;

  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [11:0] ALU_ADD = 12'h001;
  localparam logic [11:0] ALU_SUB = 12'h002;
  localparam logic [11:0] ALU_AND = 12'h004;
  localparam logic [11:0] ALU_OR  = 12'h008;

  typedef enum logic [4:0] {
    S_RST  = 5'd0,
    S_T0   = 5'd1,
    S_T1   = 5'd2,
    S_T2   = 5'd3,
    S_T3   = 5'd4,
    S_T4   = 5'd5,
    S_T5   = 5'd6,
    S_T6   = 5'd7,
    S_T7   = 5'd8,
    S_HALT = 5'd9
`ifdef CONTROL_SEQUENCER_STEP_EN
    , S_WAIT = 5'd10
`endif
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_LDI,
    CLS_ALU,
    CLS_BR,
    CLS_HALT
  } iclass_t;

  typedef struct packed {
    logic        pc_out;
    logic        pc_in;
    logic        inc_pc;
    logic        mar_in;
    logic        mdr_read;
    logic        mdr_in;
    logic        mdr_out;
    logic        ir_in;
    logic        gra;
    logic        grb;
    logic        grc;
    logic        rin;
    logic        rout;
    logic        ba_out;
    logic        y_in;
    logic        z_in;
    logic        zlow_out;
    logic        c_out;
    logic        con_in;
    logic        br_in;
    logic        con_ff_reset;
    logic [11:0] alu;
  } strobes_t;

  // Strobes asserted while sitting in state s for an instruction of class c.
  function automatic strobes_t strobes_for(state_t s, iclass_t c, logic [11:0] alu_op);
    strobes_t o;
    o = '0;
    case (s)
      S_T0: begin o.pc_out = 1'b1; o.mar_in = 1'b1; o.inc_pc = 1'b1; o.z_in = 1'b1; end
      S_T1: begin o.zlow_out = 1'b1; o.pc_in = 1'b1; o.mdr_read = 1'b1; o.mdr_in = 1'b1; end
      S_T2: begin o.mdr_out = 1'b1; o.ir_in = 1'b1; end
      S_T3: begin
        case (c)
          CLS_LDI: begin o.grb = 1'b1; o.ba_out = 1'b1; o.y_in = 1'b1; end
          CLS_ALU: begin o.grb = 1'b1; o.rout = 1'b1; o.y_in = 1'b1; end
          CLS_BR:  begin o.gra = 1'b1; o.rout = 1'b1; o.con_in = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (c)
          CLS_LDI: begin o.c_out = 1'b1; o.alu = ALU_ADD; o.z_in = 1'b1; end
          CLS_ALU: begin o.grc = 1'b1; o.rout = 1'b1; o.z_in = 1'b1; o.alu = alu_op; end
          CLS_BR:  begin o.pc_out = 1'b1; o.y_in = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (c)
          CLS_LDI, CLS_ALU: begin o.zlow_out = 1'b1; o.gra = 1'b1; o.rin = 1'b1; end
          CLS_BR: begin o.c_out = 1'b1; o.alu = ALU_ADD; o.z_in = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin o.zlow_out = 1'b1; o.pc_in = 1'b1; o.br_in = 1'b1; end
      S_T7: o.con_ff_reset = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/control_sequencer_opcode_decoder.sv
// Maps the 5-bit opcode to an instruction class and the ALU one-hot operation.
module opcode_decoder
  import control_sequencer_pkg::*;
(
  input  logic [4:0]  opcode,
  output iclass_t     iclass,
  output logic [11:0] alu_op
);

  always_comb begin
    iclass = CLS_NOP;
    alu_op = '0;
    case (opcode)
      OP_LDI:  iclass = CLS_LDI;
      OP_ADD:  begin iclass = CLS_ALU; alu_op = ALU_ADD; end
      OP_SUB:  begin iclass = CLS_ALU; alu_op = ALU_SUB; end
      OP_AND:  begin iclass = CLS_ALU; alu_op = ALU_AND; end
      OP_OR:   begin iclass = CLS_ALU; alu_op = ALU_OR;  end
      OP_BR:   iclass = CLS_BR;
      OP_HALT: iclass = CLS_HALT;
      default: iclass = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch T0-T2, execute T3-T7, HALT; registered strobes.
// Define CONTROL_SEQUENCER_STEP_EN to add the step input and single-step WAIT state.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        stop,
`ifdef CONTROL_SEQUENCER_STEP_EN
  input  logic        step,
`endif
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRRead,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin_in,
  output logic        Rout_in,
  output logic        BAout,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic [11:0] ALUControl,
  output logic        CONin,
  output logic        brIn,
  output logic        con_FF_Reset,
  output logic        run,
  output logic [4:0]  state_dbg
);

  state_t      state, nxt, done_nxt;
  iclass_t     iclass;
  logic [11:0] alu_op;
  strobes_t    strb;

  // Only the opcode steers sequencing; CON is evaluated by the datapath itself.
  logic unused_inputs;
  assign unused_inputs = ^{IR[26:0], CON};

  opcode_decoder u_dec (
    .opcode (IR[31:27]),
    .iclass (iclass),
    .alu_op (alu_op)
  );

  always_comb begin
`ifdef CONTROL_SEQUENCER_STEP_EN
    done_nxt = stop ? S_HALT : S_WAIT;
`else
    done_nxt = stop ? S_HALT : S_T0;
`endif
    nxt = S_RST;
    case (state)
      S_RST: nxt = S_T0;
      S_T0:  nxt = S_T1;
      S_T1:  nxt = S_T2;
      S_T2: begin
        case (iclass)
          CLS_LDI, CLS_ALU, CLS_BR: nxt = S_T3;
          CLS_HALT:                 nxt = S_HALT;
          default:                  nxt = done_nxt;
        endcase
      end
      S_T3:   nxt = S_T4;
      S_T4:   nxt = S_T5;
      S_T5:   nxt = (iclass == CLS_BR) ? S_T6 : done_nxt;
      S_T6:   nxt = S_T7;
      S_T7:   nxt = done_nxt;
      S_HALT: nxt = S_HALT;
`ifdef CONTROL_SEQUENCER_STEP_EN
      S_WAIT: nxt = step ? S_T0 : S_WAIT;
`endif
      default: nxt = S_RST;
    endcase
  end

  // Strobes are registered from the state being entered, so they align with state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= S_RST;
      strb  <= '0;
      run   <= 1'b0;
    end else begin
      state <= nxt;
      strb  <= strobes_for(nxt, iclass, alu_op);
      run   <= (nxt != S_RST) && (nxt != S_HALT);
    end
  end

  assign state_dbg    = state;
  assign PCout        = strb.pc_out;
  assign PCin         = strb.pc_in;
  assign IncPC        = strb.inc_pc;
  assign MARin        = strb.mar_in;
  assign MDRRead      = strb.mdr_read;
  assign MDRin        = strb.mdr_in;
  assign MDRout       = strb.mdr_out;
  assign IRin         = strb.ir_in;
  assign Gra          = strb.gra;
  assign Grb          = strb.grb;
  assign Grc          = strb.grc;
  assign Rin_in       = strb.rin;
  assign Rout_in      = strb.rout;
  assign BAout        = strb.ba_out;
  assign Yin          = strb.y_in;
  assign Zin          = strb.z_in;
  assign Zlowout      = strb.zlow_out;
  assign Cout         = strb.c_out;
  assign ALUControl   = strb.alu;
  assign CONin        = strb.con_in;
  assign brIn         = strb.br_in;
  assign con_FF_Reset = strb.con_ff_reset;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed cases plus random instruction stream.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  typedef logic [33:0] vec_t;

  localparam vec_t RUN  = vec_t'(1) << 0;
  localparam vec_t CFR  = vec_t'(1) << 13;
  localparam vec_t BRI  = vec_t'(1) << 14;
  localparam vec_t CONI = vec_t'(1) << 15;
  localparam vec_t COUT = vec_t'(1) << 16;
  localparam vec_t ZLO  = vec_t'(1) << 17;
  localparam vec_t ZIN  = vec_t'(1) << 18;
  localparam vec_t YIN  = vec_t'(1) << 19;
  localparam vec_t BAO  = vec_t'(1) << 20;
  localparam vec_t ROUT = vec_t'(1) << 21;
  localparam vec_t RIN  = vec_t'(1) << 22;
  localparam vec_t GRC  = vec_t'(1) << 23;
  localparam vec_t GRB  = vec_t'(1) << 24;
  localparam vec_t GRA  = vec_t'(1) << 25;
  localparam vec_t IRI  = vec_t'(1) << 26;
  localparam vec_t MDRO = vec_t'(1) << 27;
  localparam vec_t MDRI = vec_t'(1) << 28;
  localparam vec_t MDRR = vec_t'(1) << 29;
  localparam vec_t MARI = vec_t'(1) << 30;
  localparam vec_t INCP = vec_t'(1) << 31;
  localparam vec_t PCI  = vec_t'(1) << 32;
  localparam vec_t PCO  = vec_t'(1) << 33;

  localparam vec_t FETCH0 = PCO | MARI | INCP | ZIN | RUN;
  localparam vec_t FETCH1 = ZLO | PCI | MDRR | MDRI | RUN;
  localparam vec_t FETCH2 = MDRO | IRI | RUN;

  logic        clk, clr, CON, stop, step;
  logic [31:0] IR;
  logic        PCout, PCin, IncPC, MARin, MDRRead, MDRin, MDRout, IRin;
  logic        Gra, Grb, Grc, Rin_in, Rout_in, BAout, Yin, Zin, Zlowout, Cout;
  logic [11:0] ALUControl;
  logic        CONin, brIn, con_FF_Reset, run;
  logic [4:0]  state_dbg;

  int unsigned total = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;
  vec_t exp_q[$];

  control_sequencer dut (
    .clk(clk), .clr(clr), .IR(IR), .CON(CON), .stop(stop),
`ifdef CONTROL_SEQUENCER_STEP_EN
    .step(step),
`endif
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .MDRRead(MDRRead), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin_in(Rin_in), .Rout_in(Rout_in), .BAout(BAout),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout), .ALUControl(ALUControl),
    .CONin(CONin), .brIn(brIn), .con_FF_Reset(con_FF_Reset), .run(run), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t obs();
    return {PCout, PCin, IncPC, MARin, MDRRead, MDRin, MDRout, IRin, Gra, Grb, Grc,
            Rin_in, Rout_in, BAout, Yin, Zin, Zlowout, Cout, CONin, brIn, con_FF_Reset,
            ALUControl, run};
  endfunction

  function automatic vec_t aluv(input int unsigned code);
    return vec_t'(code) << 1;
  endfunction

  // Reference sequence of per-cycle strobes, T0 through the instruction's final state.
  function automatic void build(input logic [4:0] op);
    exp_q.delete();
    exp_q.push_back(FETCH0);
    exp_q.push_back(FETCH1);
    exp_q.push_back(FETCH2);
    if (op == 5'b00001) begin
      exp_q.push_back(GRB | BAO | YIN | RUN);
      exp_q.push_back(COUT | aluv(1) | ZIN | RUN);
      exp_q.push_back(ZLO | GRA | RIN | RUN);
    end else if (op >= 5'b00011 && op <= 5'b00110) begin
      exp_q.push_back(GRB | ROUT | YIN | RUN);
      exp_q.push_back(GRC | ROUT | ZIN | aluv(1 << (op - 5'd3)) | RUN);
      exp_q.push_back(ZLO | GRA | RIN | RUN);
    end else if (op == 5'b10010) begin
      exp_q.push_back(GRA | ROUT | CONI | RUN);
      exp_q.push_back(PCO | YIN | RUN);
      exp_q.push_back(COUT | aluv(1) | ZIN | RUN);
      exp_q.push_back(ZLO | PCI | BRI | RUN);
      exp_q.push_back(CFR | RUN);
    end
  endfunction

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic recover(input string tag);
    clr = 1'b0;
    #1;
    check({tag, "_rst_out"}, obs(), '0);
    check({tag, "_rst_state"}, vec_t'(state_dbg), vec_t'(S_RST));
    tick();
    stop = 1'b0;
    step = 1'b0;
    clr  = 1'b1;
    tick();
    check({tag, "_t0_out"}, obs(), FETCH0);
    check({tag, "_t0_state"}, vec_t'(state_dbg), vec_t'(S_T0));
  endtask

  // Runs one instruction starting in T0; stop_idx/abort_idx < 0 disables that event.
  task automatic do_instr(input logic [4:0] op, input logic con, input int stop_idx,
                          input int abort_idx, input string tag);
    int last;
    bit halted;
    IR  = {op, 27'($urandom)};
    CON = con;
    build(op);
    last = exp_q.size() - 1;
    for (int i = 0; i <= last; i++) begin
      if (i > 0) tick();
      check($sformatf("%s_c%0d", tag, i), obs(), exp_q[i]);
      if (i == abort_idx) begin
        #2 clr = 1'b0;
        #1;
        check({tag, "_abort_out"}, obs(), '0);
        check({tag, "_abort_state"}, vec_t'(state_dbg), vec_t'(S_RST));
        #2 clr = 1'b1;
        tick();
        check({tag, "_abort_t0"}, obs(), FETCH0);
        return;
      end
      if (i == stop_idx) stop = 1'b1;
    end
    halted = (op == 5'b11011) || (stop_idx >= 0 && stop_idx <= last);
    tick();
    if (halted) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("%s_halt%0d", tag, k), obs(), '0);
        check($sformatf("%s_halt_state%0d", tag, k), vec_t'(state_dbg), vec_t'(S_HALT));
        tick();
      end
      recover(tag);
    end else begin
`ifdef CONTROL_SEQUENCER_STEP_EN
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        check($sformatf("%s_wait%0d", tag, k), obs(), RUN);
        tick();
      end
      check({tag, "_wait_last"}, obs(), RUN);
      step = 1'b1;
      tick();
      step = 1'b0;
`endif
      check({tag, "_next_t0"}, obs(), FETCH0);
    end
  endtask

  function automatic bit is_defined(input logic [4:0] op);
    return op == 5'b00001 || (op >= 5'b00011 && op <= 5'b00110) ||
           op == 5'b10010 || op == 5'b11010 || op == 5'b11011;
  endfunction

  initial begin
    logic [4:0] op;
    int unsigned r;
    int sidx;
    clr = 1'b0; IR = '0; CON = 1'b0; stop = 1'b0; step = 1'b0;
    #3;
    check("reset_out", obs(), '0);
    check("reset_state", vec_t'(state_dbg), vec_t'(S_RST));
    tick();
    tick();
    check("reset_hold_out", obs(), '0);
    clr = 1'b1;
    #2;
    check("release_state", vec_t'(state_dbg), vec_t'(S_RST));
    tick();
    check("first_t0_out", obs(), FETCH0);
    check("first_t0_state", vec_t'(state_dbg), vec_t'(S_T0));

    do_instr(5'b00001, 1'b0, -1, -1, "ldi");
    do_instr(5'b10010, 1'b0, -1, -1, "br_con0");
    do_instr(5'b10010, 1'b1, -1, -1, "br_con1");
    do_instr(5'b00011, 1'b0, -1, -1, "add");
    do_instr(5'b00101, 1'b1, -1, -1, "and");
    do_instr(5'b00110, 1'b0, -1, -1, "or");
    do_instr(5'b11111, 1'b0, -1, -1, "undef");
    do_instr(5'b11010, 1'b1, -1, -1, "nop");
    do_instr(5'b00100, 1'b0, 4, -1, "sub_stop");
    do_instr(5'b10010, 1'b1, -1, 5, "br_abort");
    do_instr(5'b11011, 1'b0, -1, -1, "halt_op");
    do_instr(5'b11010, 1'b0, 2, -1, "nop_stop");

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 8);
      case (r)
        0: op = 5'b00001;
        1, 2, 3, 4: op = 5'(r + 2);
        5: op = 5'b10010;
        6: op = 5'b11010;
        default: begin
          op = 5'($urandom);
          if (is_defined(op)) op = 5'b11111;
        end
      endcase
      sidx = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1;
      do_instr(op, 1'($urandom), sidx, -1, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
